// File: rtl/des_result_reader_if.sv
// Bus bundle between des_result_reader and its surroundings.
//   ram_addr/ram_en/ram_dout : synchronous-read port of the DES output block RAM
//   blk_data/blk_valid/blk_ready : 64-bit result stream to downstream logic
// master = reader side, slave = RAM + stream consumer side.
interface des_result_reader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [31:0]       ram_dout;
  logic [63:0]       blk_data;
  logic              blk_valid;
  logic              blk_ready;

  modport master (
    output ram_addr,
    output ram_en,
    input  ram_dout,
    output blk_data,
    output blk_valid,
    input  blk_ready
  );

  modport slave (
    input  ram_addr,
    input  ram_en,
    output ram_dout,
    input  blk_data,
    input  blk_valid,
    output blk_ready
  );
endinterface

// File: rtl/des_result_reader.sv
// Reader for the DES output block RAM. On a start pulse it reads 2*NUM_BLOCKS 32-bit words
// (sync read, 1-cycle latency), pairs word 2k (low) with word 2k+1 (high) into a 64-bit
// block and offers each block on a valid/ready stream. Single clock domain (dcm_clk).
//
// Ports:
//   dcm_clk    clock
//   reset      synchronous, active-high
//   start_i    1-cycle pulse, begins a pass at address 0 (ignored while busy)
//   bus_io     master side of des_result_reader_if (RAM read port + result stream)
//   busy_o     high from start acceptance until done
//   done_o     1-cycle pulse two cycles after the last block handshake
//   checksum_o XOR of all accepted blocks of the current/last pass
//
// Build option: define DES_RDR_CHECKSUM_EN to include the checksum accumulator;
// otherwise checksum_o is tied to zero.
module des_result_reader #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned NUM_BLOCKS = 256
) (
  input  logic                       dcm_clk,
  input  logic                       reset,
  input  logic                       start_i,
  des_result_reader_if.master        bus_io,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [63:0]                checksum_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StCap,
    StPresent,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] idx_inc;
  logic              en_q, en_d;
  logic [63:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_acc;
  logic              handshake;

  assign idx_inc   = idx_q + ADDR_W'(1);
  assign start_acc = (state_q == StIdle) && start_i;
  // valid_q is high exactly while in StPresent
  assign handshake = (state_q == StPresent) && bus_io.blk_ready;

  always_ff @(posedge dcm_clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    en_d    = en_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          state_d = StRdLo;
        end
      end
      StRdLo: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StRdHi;
      end
      StRdHi: begin
        // RAM now shows word 2k, read issued two edges ago
        data_d[31:0] = bus_io.ram_dout;
        state_d      = StCap;
      end
      StCap: begin
        data_d[63:32] = bus_io.ram_dout;
        valid_d       = 1'b1;
        state_d       = StPresent;
      end
      StPresent: begin
        if (bus_io.blk_ready) begin
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_inc;
            addr_d  = {idx_inc[ADDR_W-2:0], 1'b0};
            state_d = StRdLo;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DES_RDR_CHECKSUM_EN
  logic [63:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = '0;
    end else if (handshake) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge dcm_clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`else
  logic unused_hs;
  assign unused_hs  = start_acc ^ handshake;
  assign checksum_o = '0;
`endif

  assign bus_io.ram_addr  = addr_q;
  assign bus_io.ram_en    = en_q;
  assign bus_io.blk_data  = data_q;
  assign bus_io.blk_valid = valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_des_result_reader.sv
// Self-checking bench for des_result_reader: a cycle table for a 1-block instance, then
// full 256-block passes on a second instance with back-to-back, stalled, random ready,
// ignored restart, mid-pass reset and random RAM contents.
module tb_des_result_reader;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic        busy0, busy1, done0, done1;
  logic [63:0] csum0, csum1;
  logic [31:0] mem [0:511];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  des_result_reader_if #(.ADDR_W(9)) bus0 ();
  des_result_reader_if #(.ADDR_W(9)) bus1 ();

  des_result_reader #(.ADDR_W(9), .NUM_BLOCKS(NB)) dut0 (
    .dcm_clk    (clk),
    .reset      (reset),
    .start_i    (start0),
    .bus_io     (bus0),
    .busy_o     (busy0),
    .done_o     (done0),
    .checksum_o (csum0)
  );

  des_result_reader #(.ADDR_W(9), .NUM_BLOCKS(1)) dut1 (
    .dcm_clk    (clk),
    .reset      (reset),
    .start_i    (start1),
    .bus_io     (bus1),
    .busy_o     (busy1),
    .done_o     (done1),
    .checksum_o (csum1)
  );

  // Synchronous-read RAM models sharing one content array
  always @(posedge clk) if (bus0.ram_en) bus0.ram_dout <= mem[bus0.ram_addr];
  always @(posedge clk) if (bus1.ram_en) bus1.ram_dout <= mem[bus1.ram_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_blk(input int k);
    return {mem[2*k+1], mem[2*k]};
  endfunction

  function automatic logic [63:0] exp_csum(input logic [63:0] acc);
`ifdef DES_RDR_CHECKSUM_EN
    return acc;
`else
    return 64'd0 & acc;
`endif
  endfunction

  // mode 0: ready always high; 1: ready low for 10 cycles at block 5; 2: random ready.
  // restart: pulse start again while block 100 is presented.
  task automatic run_pass(input int mode, input bit restart);
    int k = 0, stall = 0, last_hs = -1, done_cnt = 0, done_c = -1, first_v = -1;
    bit sent = 1'b0;
    logic [63:0] acc = '0;
    @(negedge clk);
    start0 = 1'b1;
    bus0.blk_ready = (mode == 0);
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c == 1) chk("busy_after_start", 64'(busy0), 64'd1);
      if (done0) begin
        done_cnt++;
        done_c = c;
        chk("busy_low_at_done", 64'(busy0), 64'd0);
        chk("checksum_at_done", csum0, exp_csum(acc));
      end
      if (bus0.blk_valid && first_v < 0) first_v = c;
      if (restart && !sent && k == 100 && bus0.blk_valid) begin
        start0 = 1'b1;
        sent = 1'b1;
      end
      case (mode)
        0: bus0.blk_ready = 1'b1;
        1: begin
          if (k == 5 && stall < 10 && bus0.blk_valid) begin
            bus0.blk_ready = 1'b0;
            stall++;
            chk("stall_data", bus0.blk_data, exp_blk(5));
            chk("stall_addr", 64'(bus0.ram_addr), 64'd11);
          end else begin
            bus0.blk_ready = 1'b1;
          end
        end
        default: bus0.blk_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus0.blk_valid && bus0.blk_ready) begin
        chk("blk_data", bus0.blk_data, exp_blk(k));
        if (mode == 0) chk("blk_spacing", 64'(c), 64'(4 + 4 * k));
        acc ^= exp_blk(k);
        k++;
        last_hs = c;
      end
      if (done_c > 0 && c >= done_c + 2) break;
    end
    bus0.blk_ready = 1'b0;
    chk("first_valid_t4", 64'(first_v), 64'd4);
    chk("block_count", 64'(k), 64'(NB));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_latency", 64'(done_c), 64'(last_hs + 2));
    chk("busy_after_done", 64'(busy0), 64'd0);
    chk("checksum_held", csum0, exp_csum(acc));
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic [8:0]  addr;
    logic        en;
    logic        valid;
    logic        busy;
    logic        done;
    logic [63:0] data;
  } vec_t;

  initial begin
    vec_t tbl [8];
    bit   seen_done;

    for (int n = 0; n < 512; n++) mem[n] = 32'(n);

    // 1-block instance, one row per cycle: inputs, then outputs after the next edge
    tbl[0] = '{1'b1, 1'b1, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 1'b1, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[2] = '{1'b0, 1'b1, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[3] = '{1'b0, 1'b1, 9'd1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h00000001_00000000};
    tbl[4] = '{1'b0, 1'b1, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00000001_00000000};
    tbl[5] = '{1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00000001_00000000};
    tbl[6] = '{1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h00000001_00000000};
    tbl[7] = '{1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h00000001_00000000};

    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    bus0.blk_ready = 1'b0;
    bus1.blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(bus0.ram_addr), 64'd0);
    chk("rst_en", 64'(bus0.ram_en), 64'd0);
    chk("rst_data", bus0.blk_data, 64'd0);
    chk("rst_valid", 64'(bus0.blk_valid), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_checksum", csum0, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start1 = tbl[i].start;
      bus1.blk_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("nb1_addr[%0d]", i), 64'(bus1.ram_addr), 64'(tbl[i].addr));
      chk($sformatf("nb1_en[%0d]", i), 64'(bus1.ram_en), 64'(tbl[i].en));
      chk($sformatf("nb1_valid[%0d]", i), 64'(bus1.blk_valid), 64'(tbl[i].valid));
      chk($sformatf("nb1_busy[%0d]", i), 64'(busy1), 64'(tbl[i].busy));
      chk($sformatf("nb1_done[%0d]", i), 64'(done1), 64'(tbl[i].done));
      chk($sformatf("nb1_data[%0d]", i), bus1.blk_data, tbl[i].data);
    end
    chk("nb1_checksum", csum1, exp_csum(64'h00000001_00000000));
    start1 = 1'b0;
    bus1.blk_ready = 1'b0;

    run_pass(0, 1'b0);
    run_pass(1, 1'b0);
    run_pass(0, 1'b1);

    // Reset while block 50 is presented
    @(negedge clk);
    start0 = 1'b1;
    bus0.blk_ready = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (203) @(negedge clk);
    chk("pre_reset_valid", 64'(bus0.blk_valid), 64'd1);
    chk("pre_reset_data", bus0.blk_data, exp_blk(50));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 64'(bus0.blk_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_done", 64'(done0), 64'd0);
    chk("mid_rst_en", 64'(bus0.ram_en), 64'd0);
    chk("mid_rst_addr", 64'(bus0.ram_addr), 64'd0);
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    chk("no_done_after_reset", 64'(seen_done), 64'd0);
    bus0.blk_ready = 1'b0;
    run_pass(0, 1'b0);

    for (int n = 0; n < 512; n++) mem[n] = $urandom;
    run_pass(2, 1'b0);
    run_pass(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
